// File: rtl/race_pkg.sv
// Shared types and constants for the race game-state engine.
package race_pkg;

  typedef enum logic [1:0] {
    MENU      = 2'd0,
    COUNTDOWN = 2'd1,
    RACE      = 2'd2,
    FINISHED  = 2'd3
  } state_e;

  localparam int unsigned GREEN  = 0;
  localparam int unsigned RED    = 1;
  localparam int unsigned BLUE   = 2;
  localparam int unsigned YELLOW = 3;

  localparam int unsigned NUM_PLAYERS = 4;
  localparam int unsigned POS_W       = 7;

endpackage

// File: rtl/race_controller_press_detect.sv
// One-bit rising-edge detector. The history register resets to 1 so a
// button already held when reset releases does not register as a press.
module press_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic hist_q;

  // Remember the previous sample of the button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 1'b1;
    else     hist_q <= btn_i;
  end

  assign press_o = btn_i & ~hist_q;

endmodule

// File: rtl/race_controller.sv
// Game-state engine: menu/join, start countdown, per-player position
// counters and end-of-race freeze feeding the screen router.
module race_controller
  import race_pkg::*;
#(
  parameter int unsigned MAX_POS          = 109,
  parameter int unsigned COUNTDOWN_CYCLES = 150000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_green,
  input  logic       btn_red,
  input  logic       btn_blue,
  input  logic       btn_yellow,
  input  logic       btn_start,
  output logic [6:0] green_cur_pos,
  output logic [6:0] red_cur_pos,
  output logic [6:0] blue_cur_pos,
  output logic [6:0] yellow_cur_pos,
  output logic       is_in_menu,
  output logic       countdown_active,
  output logic [3:0] joined_mask,
  output logic [3:0] winner_mask
);

  localparam int unsigned CNT_W = $clog2(COUNTDOWN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNTDOWN_CYCLES - 1);
  localparam logic [POS_W-1:0] MAX_P    = POS_W'(MAX_POS);

  state_e                                state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [NUM_PLAYERS-1:0][POS_W-1:0]     pos_q, pos_d;
  logic [NUM_PLAYERS-1:0]                joined_q, joined_d;
  logic [NUM_PLAYERS-1:0]                winner_q, winner_d;
  logic [NUM_PLAYERS-1:0]                hit;

  logic [NUM_PLAYERS-1:0] btn_w;
  logic [NUM_PLAYERS-1:0] press_w;
  logic                   start_press;

  assign btn_w = {btn_yellow, btn_blue, btn_red, btn_green};

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player_pd
    press_detect u_pd (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_w[g]),
      .press_o (press_w[g])
    );
  end

  press_detect u_pd_start (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_start),
    .press_o (start_press)
  );

  // State, countdown, positions and masks register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MENU;
      cnt_q    <= '0;
      pos_q    <= '0;
      joined_q <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      joined_q <= joined_d;
      winner_q <= winner_d;
    end
  end

  // Next-state logic for the game phases.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    joined_d = joined_q;
    winner_d = winner_q;
    hit      = '0;
    case (state_q)
      MENU: begin
        // Joins land first so a simultaneous start sees the new mask.
        joined_d = joined_q | press_w;
        if (start_press && (joined_d != '0)) begin
          state_d = COUNTDOWN;
          cnt_d   = '0;
        end
      end
      COUNTDOWN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RACE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RACE: begin
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
          if (joined_q[i] && press_w[i] && (pos_q[i] < MAX_P))
            pos_d[i] = pos_q[i] + POS_W'(1);
          hit[i] = (pos_d[i] == MAX_P);
        end
        if (hit != '0) begin
          state_d  = FINISHED;
          winner_d = hit;
        end
      end
      FINISHED: begin
        if (start_press) begin
          state_d  = MENU;
          cnt_d    = '0;
          pos_d    = '0;
          joined_d = '0;
          winner_d = '0;
        end
      end
      default: begin
        state_d  = MENU;
        cnt_d    = '0;
        pos_d    = '0;
        joined_d = '0;
        winner_d = '0;
      end
    endcase
  end

  assign green_cur_pos    = pos_q[GREEN];
  assign red_cur_pos      = pos_q[RED];
  assign blue_cur_pos     = pos_q[BLUE];
  assign yellow_cur_pos   = pos_q[YELLOW];
  assign is_in_menu       = (state_q == MENU) || (state_q == COUNTDOWN);
  assign countdown_active = (state_q == COUNTDOWN);
  assign joined_mask      = joined_q;
  assign winner_mask      = winner_q;

endmodule
